// File: rtl/mips_port_io_controller.sv
// Memory-mapped port I/O for the single-cycle MIPS core: OUT register, synchronized IN, edge STATUS/MASK/IRQ.
// Loads are combinational (same cycle); stores land on the next edge; no backpressure. Edge/IRQ logic: PORT_IO_EDGE_IRQ_EN.
module mips_port_io_controller #(
    parameter logic [31:0] BASE_ADDR = 32'h1001_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemWrite,
    input  logic        MemRead,
    input  logic [31:0] Address,
    input  logic [31:0] WriteData,
    output logic [31:0] ReadData,
    output logic        Hit,
    input  logic [7:0]  PortIn,
    output logic [31:0] PortOut,
    output logic        IRQ
);
    localparam logic [2:0] OFF_OUT    = 3'd0;
    localparam logic [2:0] OFF_SET    = 3'd1;
    localparam logic [2:0] OFF_CLR    = 3'd2;
    localparam logic [2:0] OFF_TGL    = 3'd3;
    localparam logic [2:0] OFF_IN     = 3'd4;
`ifdef PORT_IO_EDGE_IRQ_EN
    localparam logic [2:0] OFF_STATUS = 3'd5;
    localparam logic [2:0] OFF_MASK   = 3'd6;
`endif

    logic [2:0]  reg_sel;
    logic        wr_en;
    logic        rd_en;
    logic [31:0] out_q, out_d;
    logic [7:0]  sync1_q, sync1_d;
    logic [7:0]  sync2_q, sync2_d;

    assign reg_sel = Address[4:2];
    assign Hit     = (Address[31:5] == BASE_ADDR[31:5]) && (Address[1:0] == 2'b00)
                     && (MemRead || MemWrite);
    assign wr_en   = Hit && MemWrite;
    assign rd_en   = Hit && MemRead;
    assign PortOut = out_q;

    always_comb begin
        out_d   = out_q;
        sync1_d = PortIn;
        sync2_d = sync1_q;
        if (wr_en) begin
            case (reg_sel)
                OFF_OUT: out_d = WriteData;
                OFF_SET: out_d = out_q | WriteData;
                OFF_CLR: out_d = out_q & ~WriteData;
                OFF_TGL: out_d = out_q ^ WriteData;
                default: out_d = out_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_q   <= '0;
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            out_q   <= out_d;
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
        end
    end

`ifdef PORT_IO_EDGE_IRQ_EN
    logic [7:0] prev_q, prev_d;
    logic [7:0] status_q, status_d;
    logic [7:0] mask_q, mask_d;
    logic [7:0] chg;
    logic       irq_q, irq_d;

    // Hardware set is OR-ed in after the software clear so a same-edge event wins.
    always_comb begin
        chg      = sync2_q ^ prev_q;
        prev_d   = sync2_q;
        status_d = status_q;
        mask_d   = mask_q;
        if (wr_en && reg_sel == OFF_STATUS) status_d = status_q & ~WriteData[7:0];
        if (wr_en && reg_sel == OFF_MASK)   mask_d   = WriteData[7:0];
        status_d = status_d | chg;
        irq_d    = |(status_q & mask_q);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            prev_q   <= '0;
            status_q <= '0;
            mask_q   <= '0;
            irq_q    <= 1'b0;
        end else begin
            prev_q   <= prev_d;
            status_q <= status_d;
            mask_q   <= mask_d;
            irq_q    <= irq_d;
        end
    end

    assign IRQ = irq_q;
`else
    assign IRQ = 1'b0;
`endif

    // Read mux shows pre-write state, so a combined load/store returns the old value.
    always_comb begin
        ReadData = '0;
        if (rd_en) begin
            case (reg_sel)
                OFF_OUT, OFF_SET, OFF_CLR, OFF_TGL: ReadData = out_q;
                OFF_IN:     ReadData = {24'b0, sync2_q};
`ifdef PORT_IO_EDGE_IRQ_EN
                OFF_STATUS: ReadData = {24'b0, status_q};
                OFF_MASK:   ReadData = {24'b0, mask_q};
`endif
                default:    ReadData = '0;
            endcase
        end
    end
endmodule

// File: tb/tb_mips_port_io_controller.sv
// Directed plus randomized bench for mips_port_io_controller against a behavioural history-based model.
module tb_mips_port_io_controller;
    localparam logic [31:0] BASE = 32'h1001_0000;
`ifdef PORT_IO_EDGE_IRQ_EN
    localparam bit IRQ_EN = 1'b1;
`else
    localparam bit IRQ_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        MemWrite, MemRead;
    logic [31:0] Address, WriteData, ReadData, PortOut;
    logic        Hit, IRQ;
    logic [7:0]  PortIn;

    int checks = 0;
    int errors = 0;

    // model state: OUT, PortIn sampled at the last three edges (index 0 newest), STATUS, MASK, IRQ
    logic [31:0] m_out;
    logic [7:0]  m_hist [0:2];
    logic [7:0]  m_status, m_mask;
    logic        m_irq;
    logic [31:0] last_rd;
    logic        last_hit;

    mips_port_io_controller #(.BASE_ADDR(BASE)) dut (
        .clk(clk), .reset(reset), .MemWrite(MemWrite), .MemRead(MemRead),
        .Address(Address), .WriteData(WriteData), .ReadData(ReadData), .Hit(Hit),
        .PortIn(PortIn), .PortOut(PortOut), .IRQ(IRQ)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    function automatic bit m_hit(input logic [31:0] a, input logic rd, input logic wr);
        logic [31:0] d;
        d = a - BASE;
        return (rd || wr) && (d < 32) && (a % 4 == 0);
    endfunction

    function automatic logic [31:0] m_reg(input logic [31:0] a);
        case (a - BASE)
            32'd0, 32'd4, 32'd8, 32'd12: return m_out;
            32'd16: return {24'b0, m_hist[1]};
            32'd20: return IRQ_EN ? {24'b0, m_status} : 32'd0;
            32'd24: return IRQ_EN ? {24'b0, m_mask} : 32'd0;
            default: return 32'd0;
        endcase
    endfunction

    task automatic model_reset();
        m_out = '0; m_status = '0; m_mask = '0; m_irq = 1'b0;
        for (int i = 0; i < 3; i++) m_hist[i] = '0;
    endtask

    task automatic step();
        logic [31:0] d, n_out;
        logic [7:0]  n_status, n_mask, pin;
        logic        n_irq;
        bit          w;
        w        = m_hit(Address, MemRead, MemWrite) && MemWrite;
        d        = Address - BASE;
        pin      = PortIn;
        n_out    = m_out;
        n_status = m_status;
        n_mask   = m_mask;
        if (w) begin
            case (d)
                32'd0:  n_out = WriteData;
                32'd4:  n_out = m_out | WriteData;
                32'd8:  n_out = m_out & ~WriteData;
                32'd12: n_out = m_out ^ WriteData;
                32'd20: n_status = m_status & ~WriteData[7:0];
                32'd24: n_mask = WriteData[7:0];
                default: ;
            endcase
        end
        n_status = n_status | (m_hist[1] ^ m_hist[2]);
        n_irq    = |(m_status & m_mask);
        @(posedge clk);
        #1;
        m_out     = n_out;
        m_hist[2] = m_hist[1];
        m_hist[1] = m_hist[0];
        m_hist[0] = pin;
        if (IRQ_EN) begin
            m_status = n_status; m_mask = n_mask; m_irq = n_irq;
        end
        check("portout", PortOut, m_out);
        check("irq", {31'b0, IRQ}, {31'b0, m_irq});
    endtask

    task automatic access(input logic [31:0] a, input logic rd, input logic wr, input logic [31:0] wd);
        logic [31:0] exp_rd;
        Address = a; MemRead = rd; MemWrite = wr; WriteData = wd;
        #1;
        exp_rd   = (rd && m_hit(a, rd, wr)) ? m_reg(a) : 32'd0;
        last_rd  = ReadData;
        last_hit = Hit;
        check("hit", {31'b0, Hit}, {31'b0, m_hit(a, rd, wr)});
        check("rdata", ReadData, exp_rd);
        step();
        MemRead = 1'b0; MemWrite = 1'b0;
    endtask

    initial begin
        logic [31:0] a;
        int r;
        reset = 1'b0; MemRead = 1'b0; MemWrite = 1'b0;
        Address = '0; WriteData = '0; PortIn = '0;
        model_reset();
        #1;
        check("reset_portout", PortOut, 32'd0);
        check("reset_irq", {31'b0, IRQ}, 32'd0);
        @(negedge clk);
        reset = 1'b1;

        // basic store/load
        access(BASE, 1'b0, 1'b1, 32'hA5A5_0F0F);
        check("plan_store", PortOut, 32'hA5A5_0F0F);
        access(BASE, 1'b1, 1'b0, 32'd0);
        check("plan_load", last_rd, 32'hA5A5_0F0F);

        // atomic bit ops
        access(BASE, 1'b0, 1'b1, 32'h0000_00F0);
        access(BASE + 32'h04, 1'b0, 1'b1, 32'h0000_000F);
        check("plan_set", PortOut, 32'h0000_00FF);
        access(BASE + 32'h08, 1'b0, 1'b1, 32'h0000_0030);
        check("plan_clr", PortOut, 32'h0000_00CF);
        access(BASE + 32'h0C, 1'b0, 1'b1, 32'h8000_0001);
        check("plan_tgl", PortOut, 32'h8000_00CE);
        access(BASE + 32'h08, 1'b1, 1'b0, 32'd0);
        check("alias_read", last_rd, 32'h8000_00CE);

        // decode misses
        access(32'h1001_0020, 1'b1, 1'b0, 32'd0);
        check("miss_hi_hit", {31'b0, last_hit}, 32'd0);
        check("miss_hi_rd", last_rd, 32'd0);
        access(32'h1001_0002, 1'b1, 1'b0, 32'd0);
        check("miss_mis_hit", {31'b0, last_hit}, 32'd0);
        check("miss_mis_rd", last_rd, 32'd0);
        access(32'h1000_0000, 1'b1, 1'b0, 32'd0);
        check("miss_lo_hit", {31'b0, last_hit}, 32'd0);
        check("miss_lo_rd", last_rd, 32'd0);
        access(32'h1001_0020, 1'b0, 1'b1, 32'h1234_5678);
        access(32'h1001_0002, 1'b0, 1'b1, 32'h1234_5678);
        access(32'h1000_0000, 1'b0, 1'b1, 32'h1234_5678);
        check("miss_store", PortOut, 32'h8000_00CE);

        // combined load/store returns pre-write value
        access(BASE, 1'b1, 1'b1, 32'h0000_0011);
        check("rmw_old", last_rd, 32'h8000_00CE);
        check("rmw_new", PortOut, 32'h0000_0011);

        // input path and IRQ
        access(BASE + 32'h18, 1'b0, 1'b1, 32'h0000_0004);
        PortIn = 8'h04;
        step();
        step();
        access(BASE + 32'h10, 1'b1, 1'b0, 32'd0);
        check("plan_in", last_rd, 32'h0000_0004);
        access(BASE + 32'h14, 1'b1, 1'b0, 32'd0);
        check("plan_status", last_rd, IRQ_EN ? 32'h4 : 32'h0);
        check("plan_irq", {31'b0, IRQ}, {31'b0, IRQ_EN});
        access(BASE + 32'h14, 1'b0, 1'b1, 32'h0000_0004);
        step();
        check("plan_irq_clr", {31'b0, IRQ}, 32'd0);

        // set/clear collision on STATUS[2]
        PortIn = 8'h00;
        step();
        step();
        access(BASE + 32'h14, 1'b0, 1'b1, 32'h0000_0004);
        access(BASE + 32'h14, 1'b1, 1'b0, 32'd0);
        check("plan_collide", last_rd, IRQ_EN ? 32'h4 : 32'h0);

        // async reset mid-operation
        access(BASE, 1'b0, 1'b1, 32'hFFFF_FFFF);
        check("pre_rst_out", PortOut, 32'hFFFF_FFFF);
        check("pre_rst_irq", {31'b0, IRQ}, {31'b0, IRQ_EN});
        #2;
        reset = 1'b0;
        #1;
        check("arst_portout", PortOut, 32'd0);
        check("arst_irq", {31'b0, IRQ}, 32'd0);
        model_reset();
        @(negedge clk);
        reset = 1'b1;
        access(BASE + 32'h18, 1'b1, 1'b0, 32'd0);
        check("arst_mask", last_rd, 32'd0);
        access(BASE + 32'h14, 1'b1, 1'b0, 32'd0);
        check("arst_status", last_rd, 32'd0);

        // randomized traffic
        for (int k = 0; k < 400; k++) begin
            if ($urandom_range(0, 3) == 0) PortIn = 8'($urandom);
            r = int'($urandom_range(0, 9));
            if (r < 8)       a = BASE + 32'(4 * r);
            else if (r == 8) a = BASE + 32'($urandom_range(0, 31));
            else             a = $urandom;
            access(a, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/mips_port_io_controller.md
# mips_port_io_controller

Memory-mapped I/O block downstream of the single-cycle MIPS core's load/store path: it decodes data-side accesses to a fixed 32-byte window, owns the 32-bit `PortOut` register and samples the 8-bit `PortIn` bus. It synchronizes `PortIn`, records per-bit change events in sticky status flags and raises a maskable interrupt. The core's `PortOut` and `PortIn` connect here instead of being tied off. Loads complete in the same cycle, matching the single-cycle datapath.

## Interface
- `BASE_ADDR`, default 32'h1001_0000: byte address of the window; must be 32-byte aligned.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `MemWrite`  in  1  store strobe from the core's Control unit.
- `MemRead`  in  1  load strobe from the core's Control unit.
- `Address`  in  32  byte address, which is the core's ALU result.
- `WriteData`  in  32  store data, which is the core's ReadData2.
- `ReadData`  out  32  load data; combinational.
- `Hit`  out  1  combinational: access falls in the window; the core uses it to steer its load mux.
- `PortIn`  in  8  asynchronous external inputs.
- `PortOut`  out  32  output register value.
- `IRQ`  out  1  registered interrupt request.

## Operation
- `Hit` is 1 when `Address[31:5]` equals `BASE_ADDR[31:5]`, `Address[1:0]` is 0, and `MemRead` or `MemWrite` is high. Misaligned accesses miss.
- Register map, by byte offset:
  - 0x00 OUT: read/write.
  - 0x04 OUT_SET: write-1-to-set OUT bits.
  - 0x08 OUT_CLR: write-1-to-clear OUT bits.
  - 0x0C OUT_TGL: write-1-to-toggle OUT bits.
  - 0x10 IN: read-only; {24'b0, sync2}.
  - 0x14 STATUS: bits [7:0]; read, write-1-to-clear.
  - 0x18 MASK: bits [7:0]; read/write.
  - 0x1C: reserved.
- Reads of 0x04, 0x08 and 0x0C return the current OUT value. The reserved offset reads 0 and ignores writes.
- `ReadData` is the addressed register when `Hit && MemRead`; otherwise it is 0.
- Writes with `Hit && MemWrite` take effect at the next rising edge.
- If `MemRead` and `MemWrite` are both high, the write is performed and `ReadData` shows the pre-write value.
- `PortOut` equals the OUT register directly, with no extra stage.
- Input path: `PortIn` → sync1 → sync2 (two-flop synchronizer) → prev, where prev is sync2 delayed by one cycle.
- Change event: `chg[i] = sync2[i] ^ prev[i]`. Each event sets `STATUS[i]`, and the bit stays set until software clears it.
- Set/clear collision: if a hardware set and a software W1C hit the same STATUS bit on the same edge, the set wins and the bit stays 1.
- `IRQ` is registered as `|(STATUS & MASK)`, using the register values before the edge.

## Timing
- Reset values: OUT, sync1, sync2, prev, STATUS and MASK are all 0. `PortOut` = 0 and `IRQ` = 0.
- `ReadData` and `Hit` are combinational, so they have no reset state of their own.
- Reset asserted mid-operation clears all state immediately, with no clock needed. Pending STATUS and IRQ are lost.
- Store latency: OUT and `PortOut` update at the edge that ends the store cycle.
- A load in the following cycle returns the new value.
- Input latency, for a `PortIn` change that is stable before edge n:
  - sync1 captures it at edge n.
  - sync2 (the IN register) at edge n+1.
  - STATUS sets at edge n+2.
  - `IRQ` rises at edge n+3 if the bit is masked in.
- MASK or STATUS changes reach `IRQ` one edge after the register itself updates.
- Input pulses shorter than one clock period may be missed; this is accepted behaviour.

## Configuration
- `PORT_IO_EDGE_IRQ_EN` defined: STATUS, MASK, prev and `IRQ` logic are compiled in, as described above.
- Not defined: that logic is removed. Offsets 0x14 and 0x18 behave as reserved (read 0, writes ignored), and `IRQ` is tied to 0.
- The synchronizer and IN register are present in both builds.

## Test plan
- Reset then basic store/load: release `reset`; store 32'hA5A5_0F0F to 0x1001_0000. Expect `PortOut` = A5A5_0F0F on the next edge, and a load from 0x00 returns it.
- Atomic bit ops: starting from OUT = 0000_00F0, apply SET 0000_000F, then CLR 0000_0030, then TGL 8000_0001. Expect OUT = FF, then CF, then 8000_00CE.
- Decode: load from 0x1001_0020, 0x1001_0002 and 0x1000_0000. Expect `Hit` = 0 and `ReadData` = 0 for each; OUT is unchanged by stores to these addresses.
- Input and IRQ: with MASK = 8'h04, drive `PortIn` 00→04 before edge n. Expect IN = 04 after edge n+1, STATUS = 04 after n+2, `IRQ` = 1 after n+3. W1C 04 to STATUS; expect `IRQ` = 0 two edges later.
- Set/clear collision: W1C STATUS bit 2 on the same edge a new change on bit 2 is detected. Expect STATUS[2] stays 1.
- Async reset mid-operation: assert `reset` low between edges while OUT = FFFF_FFFF and `IRQ` = 1. Expect `PortOut` = 0 and `IRQ` = 0 immediately, without a clock edge.
